// File: rtl/layer_ctrl_pkg.sv
// Shared definitions for the layer controller: FSM state encoding,
// default memory beat width and the widths of the layer-shape fields.
package layer_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CFG   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_CAL   = 3'd3,
        ST_STORE = 3'd4,
        ST_NEXT  = 3'd5
    } state_e;

    localparam int BUS_BYTES_DEF = 4;

    localparam int KW_W     = 4;
    localparam int IFMW_W   = 8;
    localparam int IFMC_W   = 8;
    localparam int OFMW_W   = 8;
    localparam int OFMC_W   = 8;
    localparam int STRIDE_W = 2;
    localparam int TILE_W   = 8;

endpackage

// File: rtl/layer_ctrl_unit_xfer_addr_gen.sv
// Byte-address generator for one memory stream. The byte counter restarts
// on 'clear', advances by one bus beat per accepted request and stops
// requesting once it covers 'size' bytes (a partial last beat counts as a
// full one). The address is held while a request waits for ready.
module xfer_addr_gen
    import layer_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int BUS_BYTES = BUS_BYTES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              en,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] size,
    input  logic              ready,
    output logic              req,
    output logic [ADDR_W-1:0] addr,
    output logic              complete
);

    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;

    assign complete = (cnt_q >= size);
    assign req      = en && !complete;
    assign addr     = base + cnt_q;

    // Next byte count: restart on stream entry, step one beat per handshake.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (req && ready) begin
            cnt_d = cnt_q + ADDR_W'(BUS_BYTES);
        end
    end

    // Byte counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/layer_ctrl_unit.sv
// Layer controller: sequences one convolution layer as a series of output
// channel tiles (TOTAL_PE channels each). Per tile it loads input feature
// map (first tile only) and weights, hands control to the PE array, then
// stores the output tile.
// Optional feature: define LAYER_CTRL_BIAS_EN to add a bias stream that is
// loaded alongside weights during LOAD.
module layer_ctrl_unit
    import layer_ctrl_pkg::*;
#(
    parameter int TOTAL_PE  = 16,
    parameter int BUS_BYTES = BUS_BYTES_DEF,
    parameter int ADDR_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [KW_W-1:0]     KERNEL_W,
    input  logic [IFMW_W-1:0]   IFM_W,
    input  logic [IFMC_W-1:0]   IFM_C,
    input  logic [OFMW_W-1:0]   OFM_W,
    input  logic [OFMC_W-1:0]   OFM_C,
    input  logic [STRIDE_W-1:0] stride,
    input  logic [ADDR_W-1:0]   ifm_base,
    input  logic [ADDR_W-1:0]   wgt_base,
    input  logic [ADDR_W-1:0]   ofm_base,
    input  logic                ifm_ready,
    input  logic                wgt_ready,
    input  logic                ofm_ready,
    input  logic                done_compute,
`ifdef LAYER_CTRL_BIAS_EN
    input  logic [ADDR_W-1:0]   bias_base,
    input  logic                bias_ready,
    output logic                bias_req,
    output logic [ADDR_W-1:0]   bias_addr,
`endif
    output logic                ifm_req,
    output logic [ADDR_W-1:0]   ifm_addr,
    output logic                wgt_req,
    output logic [ADDR_W-1:0]   wgt_addr,
    output logic                ofm_req,
    output logic [ADDR_W-1:0]   ofm_addr,
    output logic                cal_start,
    output logic                busy,
    output logic                done,
    output logic                cfg_err,
    output logic [TILE_W-1:0]   tile_idx,
    output logic [2:0]          state_o,
    output logic [KW_W-1:0]     KERNEL_W_out,
    output logic [IFMW_W-1:0]   IFM_W_out,
    output logic [IFMC_W-1:0]   IFM_C_out,
    output logic [OFMW_W-1:0]   OFM_W_out,
    output logic [OFMC_W-1:0]   OFM_C_out,
    output logic [STRIDE_W-1:0] stride_out
);

    localparam logic [ADDR_W-1:0] PE_A = ADDR_W'(TOTAL_PE);

    state_e state_q, state_d;

    logic [KW_W-1:0]     kernel_w_q, kernel_w_d;
    logic [IFMW_W-1:0]   ifm_w_q, ifm_w_d;
    logic [IFMC_W-1:0]   ifm_c_q, ifm_c_d;
    logic [OFMW_W-1:0]   ofm_w_q, ofm_w_d;
    logic [OFMC_W-1:0]   ofm_c_q, ofm_c_d;
    logic [STRIDE_W-1:0] stride_q, stride_d;
    logic [ADDR_W-1:0]   ifm_base_q, ifm_base_d;
    logic [ADDR_W-1:0]   wgt_base_q, wgt_base_d;
    logic [ADDR_W-1:0]   ofm_base_q, ofm_base_d;
    logic [ADDR_W-1:0]   wgt_off_q, wgt_off_d;
    logic [ADDR_W-1:0]   ofm_off_q, ofm_off_d;
    logic [ADDR_W-1:0]   ifm_size_q, ifm_size_d;
    logic [ADDR_W-1:0]   wgt_size_q, wgt_size_d;
    logic [ADDR_W-1:0]   ofm_size_q, ofm_size_d;
    logic [TILE_W-1:0]   tile_idx_q, tile_idx_d;
    logic                cfg_err_q, cfg_err_d;

    logic accept_start;
    logic shape_zero;
    logic more_ch;
    logic load_clear;
    logic store_clear;
    logic load_done;
    logic ifm_cmp, wgt_cmp, ofm_cmp;

    logic [ADDR_W-1:0] ch_left;
    logic [ADDR_W-1:0] tile_ch;
    logic [ADDR_W-1:0] ifm_bytes;
    logic [ADDR_W-1:0] wgt_bytes;
    logic [ADDR_W-1:0] ofm_bytes;

    assign shape_zero = (kernel_w_q == '0) || (ifm_w_q == '0) || (ifm_c_q == '0) ||
                        (ofm_w_q == '0) || (ofm_c_q == '0) || (stride_q == '0);

    // All tile sizing is done at full address width so large layers never truncate.
    assign ch_left   = ADDR_W'(ofm_c_q) - ADDR_W'(tile_idx_q) * PE_A;
    assign tile_ch   = (ch_left < PE_A) ? ch_left : PE_A;
    assign ifm_bytes = ADDR_W'(ifm_w_q) * ADDR_W'(ifm_w_q) * ADDR_W'(ifm_c_q);
    assign wgt_bytes = ADDR_W'(kernel_w_q) * ADDR_W'(kernel_w_q) * ADDR_W'(ifm_c_q) * tile_ch;
    assign ofm_bytes = ADDR_W'(ofm_w_q) * ADDR_W'(ofm_w_q) * tile_ch;
    assign more_ch   = ((ADDR_W'(tile_idx_q) + ADDR_W'(1)) * PE_A) < ADDR_W'(ofm_c_q);

`ifdef LAYER_CTRL_BIAS_EN
    logic [ADDR_W-1:0] bias_base_q, bias_base_d;
    logic [ADDR_W-1:0] bias_size_q, bias_size_d;
    logic              bias_cmp;

    assign load_done = ifm_cmp && wgt_cmp && bias_cmp;
`else
    assign load_done = ifm_cmp && wgt_cmp;
`endif

    // FSM next state and per-state control outputs.
    always_comb begin
        state_d      = state_q;
        accept_start = 1'b0;
        cal_start    = 1'b0;
        done         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_d      = ST_CFG;
                end
            end
            ST_CFG: begin
                state_d = shape_zero ? ST_IDLE : ST_LOAD;
            end
            ST_LOAD: begin
                if (load_done) begin
                    state_d = ST_CAL;
                end
            end
            ST_CAL: begin
                cal_start = !done_compute;
                if (done_compute) begin
                    state_d = ST_STORE;
                end
            end
            ST_STORE: begin
                if (ofm_cmp) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (more_ch) begin
                    state_d = ST_CFG;
                end else begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign load_clear  = (state_q == ST_CFG) && (state_d == ST_LOAD);
    assign store_clear = (state_q == ST_CAL) && (state_d == ST_STORE);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Layer configuration latch, per-tile sizing and tile bookkeeping.
    always_comb begin
        kernel_w_d = kernel_w_q;
        ifm_w_d    = ifm_w_q;
        ifm_c_d    = ifm_c_q;
        ofm_w_d    = ofm_w_q;
        ofm_c_d    = ofm_c_q;
        stride_d   = stride_q;
        ifm_base_d = ifm_base_q;
        wgt_base_d = wgt_base_q;
        ofm_base_d = ofm_base_q;
        wgt_off_d  = wgt_off_q;
        ofm_off_d  = ofm_off_q;
        ifm_size_d = ifm_size_q;
        wgt_size_d = wgt_size_q;
        ofm_size_d = ofm_size_q;
        tile_idx_d = tile_idx_q;
        cfg_err_d  = cfg_err_q;
`ifdef LAYER_CTRL_BIAS_EN
        bias_base_d = bias_base_q;
        bias_size_d = bias_size_q;
`endif
        if (accept_start) begin
            kernel_w_d = KERNEL_W;
            ifm_w_d    = IFM_W;
            ifm_c_d    = IFM_C;
            ofm_w_d    = OFM_W;
            ofm_c_d    = OFM_C;
            stride_d   = stride;
            ifm_base_d = ifm_base;
            wgt_base_d = wgt_base;
            ofm_base_d = ofm_base;
            wgt_off_d  = '0;
            ofm_off_d  = '0;
            tile_idx_d = '0;
            cfg_err_d  = 1'b0;
`ifdef LAYER_CTRL_BIAS_EN
            bias_base_d = bias_base;
`endif
        end
        if (state_q == ST_CFG) begin
            if (shape_zero) begin
                cfg_err_d = 1'b1;
            end else begin
                // The input feature map is shared by every tile, so only tile 0 fetches it.
                ifm_size_d = (tile_idx_q == '0) ? ifm_bytes : '0;
                wgt_size_d = wgt_bytes;
                ofm_size_d = ofm_bytes;
`ifdef LAYER_CTRL_BIAS_EN
                bias_size_d = tile_ch * ADDR_W'(4);
`endif
            end
        end
        if (state_q == ST_NEXT) begin
            wgt_off_d  = wgt_off_q + wgt_size_q;
            ofm_off_d  = ofm_off_q + ofm_size_q;
            tile_idx_d = tile_idx_q + TILE_W'(1);
        end
    end

    // Configuration and tile registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kernel_w_q <= '0;
            ifm_w_q    <= '0;
            ifm_c_q    <= '0;
            ofm_w_q    <= '0;
            ofm_c_q    <= '0;
            stride_q   <= '0;
            ifm_base_q <= '0;
            wgt_base_q <= '0;
            ofm_base_q <= '0;
            wgt_off_q  <= '0;
            ofm_off_q  <= '0;
            ifm_size_q <= '0;
            wgt_size_q <= '0;
            ofm_size_q <= '0;
            tile_idx_q <= '0;
            cfg_err_q  <= 1'b0;
`ifdef LAYER_CTRL_BIAS_EN
            bias_base_q <= '0;
            bias_size_q <= '0;
`endif
        end else begin
            kernel_w_q <= kernel_w_d;
            ifm_w_q    <= ifm_w_d;
            ifm_c_q    <= ifm_c_d;
            ofm_w_q    <= ofm_w_d;
            ofm_c_q    <= ofm_c_d;
            stride_q   <= stride_d;
            ifm_base_q <= ifm_base_d;
            wgt_base_q <= wgt_base_d;
            ofm_base_q <= ofm_base_d;
            wgt_off_q  <= wgt_off_d;
            ofm_off_q  <= ofm_off_d;
            ifm_size_q <= ifm_size_d;
            wgt_size_q <= wgt_size_d;
            ofm_size_q <= ofm_size_d;
            tile_idx_q <= tile_idx_d;
            cfg_err_q  <= cfg_err_d;
`ifdef LAYER_CTRL_BIAS_EN
            bias_base_q <= bias_base_d;
            bias_size_q <= bias_size_d;
`endif
        end
    end

    xfer_addr_gen #(.ADDR_W(ADDR_W), .BUS_BYTES(BUS_BYTES)) u_ifm (
        .clk(clk), .rst_n(rst_n), .clear(load_clear), .en(state_q == ST_LOAD),
        .base(ifm_base_q), .size(ifm_size_q), .ready(ifm_ready),
        .req(ifm_req), .addr(ifm_addr), .complete(ifm_cmp)
    );

    xfer_addr_gen #(.ADDR_W(ADDR_W), .BUS_BYTES(BUS_BYTES)) u_wgt (
        .clk(clk), .rst_n(rst_n), .clear(load_clear), .en(state_q == ST_LOAD),
        .base(wgt_base_q + wgt_off_q), .size(wgt_size_q), .ready(wgt_ready),
        .req(wgt_req), .addr(wgt_addr), .complete(wgt_cmp)
    );

    xfer_addr_gen #(.ADDR_W(ADDR_W), .BUS_BYTES(BUS_BYTES)) u_ofm (
        .clk(clk), .rst_n(rst_n), .clear(store_clear), .en(state_q == ST_STORE),
        .base(ofm_base_q + ofm_off_q), .size(ofm_size_q), .ready(ofm_ready),
        .req(ofm_req), .addr(ofm_addr), .complete(ofm_cmp)
    );

`ifdef LAYER_CTRL_BIAS_EN
    // Each tile's bias (4 bytes per channel) starts at its first channel.
    xfer_addr_gen #(.ADDR_W(ADDR_W), .BUS_BYTES(BUS_BYTES)) u_bias (
        .clk(clk), .rst_n(rst_n), .clear(load_clear), .en(state_q == ST_LOAD),
        .base(bias_base_q + ADDR_W'(tile_idx_q) * PE_A * ADDR_W'(4)),
        .size(bias_size_q), .ready(bias_ready),
        .req(bias_req), .addr(bias_addr), .complete(bias_cmp)
    );
`endif

    assign busy         = (state_q != ST_IDLE);
    assign cfg_err      = cfg_err_q;
    assign tile_idx     = tile_idx_q;
    assign state_o      = state_q;
    assign KERNEL_W_out = kernel_w_q;
    assign IFM_W_out    = ifm_w_q;
    assign IFM_C_out    = ifm_c_q;
    assign OFM_W_out    = ofm_w_q;
    assign OFM_C_out    = ofm_c_q;
    assign stride_out   = stride_q;

endmodule

// File: tb/tb_layer_ctrl_unit.sv
// Self-checking bench for layer_ctrl_unit (default build, bias stream off).
// Expected beat addresses for a whole layer are precomputed into queues from
// the layer shape; a monitor pops them as beats are accepted.
module tb_layer_ctrl_unit;

    localparam int AW = 32;
    localparam int PE = 16;
    localparam int BB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [3:0] k_in = '0;
    logic [7:0] iw_in = '0, ic_in = '0, ow_in = '0, oc_in = '0;
    logic [1:0] st_in = '0;
    logic [AW-1:0] ifm_base = '0, wgt_base = '0, ofm_base = '0;
    logic ifm_ready = 1'b1, wgt_ready = 1'b1, ofm_ready = 1'b1, done_compute = 1'b0;

    logic ifm_req, wgt_req, ofm_req, cal_start, busy, done, cfg_err;
    logic [AW-1:0] ifm_addr, wgt_addr, ofm_addr;
    logic [7:0] tile_idx;
    logic [2:0] state_o;
    logic [3:0] k_out;
    logic [7:0] iw_out, ic_out, ow_out, oc_out;
    logic [1:0] st_out;

    layer_ctrl_unit #(.TOTAL_PE(PE), .BUS_BYTES(BB), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .KERNEL_W(k_in), .IFM_W(iw_in), .IFM_C(ic_in), .OFM_W(ow_in), .OFM_C(oc_in), .stride(st_in),
        .ifm_base(ifm_base), .wgt_base(wgt_base), .ofm_base(ofm_base),
        .ifm_ready(ifm_ready), .wgt_ready(wgt_ready), .ofm_ready(ofm_ready),
        .done_compute(done_compute),
        .ifm_req(ifm_req), .ifm_addr(ifm_addr), .wgt_req(wgt_req), .wgt_addr(wgt_addr),
        .ofm_req(ofm_req), .ofm_addr(ofm_addr), .cal_start(cal_start),
        .busy(busy), .done(done), .cfg_err(cfg_err), .tile_idx(tile_idx), .state_o(state_o),
        .KERNEL_W_out(k_out), .IFM_W_out(iw_out), .IFM_C_out(ic_out),
        .OFM_W_out(ow_out), .OFM_C_out(oc_out), .stride_out(st_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [AW-1:0] q_ifm[$], q_wgt[$], q_ofm[$];
    int ifm_total, wgt_total, ofm_total, ntiles;
    int cum_wgt[64];
    int cum_ofm[64];
    int ifm_seen, wgt_seen, ofm_seen, dones_seen, cals_seen;
    int ifm_late, wgt_stall_obs;
    logic [AW-1:0] t1_wgt_first, t1_ofm_first;
    bit t1_wgt_got, t1_ofm_got;

    task automatic reset_model();
        q_ifm.delete(); q_wgt.delete(); q_ofm.delete();
        ifm_total = 0; wgt_total = 0; ofm_total = 0; ntiles = 0;
        ifm_seen = 0; wgt_seen = 0; ofm_seen = 0; dones_seen = 0; cals_seen = 0;
        ifm_late = 0; wgt_stall_obs = 0;
        t1_wgt_got = 0; t1_ofm_got = 0; t1_wgt_first = '0; t1_ofm_first = '0;
    endtask

    // Every beat of a layer: IFM once, then per tile the weight block and the
    // output block, each tile's block packed directly after the previous one.
    task automatic build_model(input int k, iw, ic, ow, oc, input logic [AW-1:0] ib, wb, ob);
        int woff, ooff, ch, wbytes, obytes;
        reset_model();
        for (int a = 0; a < iw * iw * ic; a += BB) q_ifm.push_back(ib + AW'(a));
        ifm_total = q_ifm.size();
        ntiles = (oc + PE - 1) / PE;
        woff = 0; ooff = 0;
        for (int t = 0; t < ntiles; t++) begin
            ch = (oc - t * PE < PE) ? oc - t * PE : PE;
            wbytes = k * k * ic * ch;
            obytes = ow * ow * ch;
            for (int a = 0; a < wbytes; a += BB) q_wgt.push_back(wb + AW'(woff + a));
            for (int a = 0; a < obytes; a += BB) q_ofm.push_back(ob + AW'(ooff + a));
            cum_wgt[t] = q_wgt.size();
            cum_ofm[t] = q_ofm.size();
            woff += wbytes;
            ooff += obytes;
        end
        wgt_total = q_wgt.size();
        ofm_total = q_ofm.size();
    endtask

    // ---------------- environment drivers ----------------
    int rdy_mode = 0;      // 0: always ready, 1: random, 2: one 10-cycle weight stall
    int cal_dly = 1;
    int cal_wait = 0;
    int stall_left = 0;
    bit stall_used = 0;

    initial forever begin
        @(posedge clk);
        #2;
        case (rdy_mode)
            1: begin
                ifm_ready = ($urandom_range(0, 3) != 0);
                wgt_ready = ($urandom_range(0, 3) != 0);
                ofm_ready = ($urandom_range(0, 3) != 0);
            end
            2: begin
                ifm_ready = 1'b1;
                ofm_ready = 1'b1;
                if (!stall_used && wgt_seen >= 20) begin
                    stall_used = 1;
                    stall_left = 10;
                end
                wgt_ready = (stall_left == 0);
                if (stall_left > 0) stall_left--;
            end
            default: begin
                ifm_ready = 1'b1; wgt_ready = 1'b1; ofm_ready = 1'b1;
            end
        endcase
        // PE array: finishes a tile a few cycles after it is started.
        if (cal_start) begin
            cal_wait++;
            if (cal_wait >= cal_dly + 2) done_compute = 1'b1;
        end else begin
            done_compute = 1'b0;
            cal_wait = 0;
        end
    end

    // ---------------- monitor / compare ----------------
    bit ifm_stall_p, wgt_stall_p, ofm_stall_p, cal_p;
    logic [AW-1:0] ifm_addr_p, wgt_addr_p, ofm_addr_p;
    int ti;

    always @(negedge clk) begin
        if (!rst_n) begin
            ifm_stall_p = 0; wgt_stall_p = 0; ofm_stall_p = 0; cal_p = 0;
        end else begin
            ti = int'(tile_idx);
            if (ifm_req) begin
                if (ifm_stall_p) chk("ifm_addr_hold", ifm_addr, ifm_addr_p);
                if (ifm_ready) begin
                    if (q_ifm.size() == 0) chk("ifm_unexpected_beat", 1, 0);
                    else chk("ifm_addr", ifm_addr, q_ifm.pop_front());
                    ifm_seen++;
                    if (ti != 0) ifm_late++;
                end
            end
            ifm_stall_p = ifm_req && !ifm_ready; ifm_addr_p = ifm_addr;

            if (wgt_req) begin
                if (wgt_stall_p) chk("wgt_addr_hold", wgt_addr, wgt_addr_p);
                if (!wgt_ready) wgt_stall_obs++;
                if (wgt_ready) begin
                    if (q_wgt.size() == 0) chk("wgt_unexpected_beat", 1, 0);
                    else chk("wgt_addr", wgt_addr, q_wgt.pop_front());
                    if (ti == 1 && !t1_wgt_got) begin t1_wgt_got = 1; t1_wgt_first = wgt_addr; end
                    wgt_seen++;
                end
            end
            wgt_stall_p = wgt_req && !wgt_ready; wgt_addr_p = wgt_addr;

            if (ofm_req) begin
                if (ofm_stall_p) chk("ofm_addr_hold", ofm_addr, ofm_addr_p);
                if (ofm_ready) begin
                    if (q_ofm.size() == 0) chk("ofm_unexpected_beat", 1, 0);
                    else chk("ofm_addr", ofm_addr, q_ofm.pop_front());
                    if (ti == 1 && !t1_ofm_got) begin t1_ofm_got = 1; t1_ofm_first = ofm_addr; end
                    ofm_seen++;
                end
            end
            ofm_stall_p = ofm_req && !ofm_ready; ofm_addr_p = ofm_addr;

            if (cal_start) chk("cal_no_req", {ifm_req, wgt_req, ofm_req}, 0);
            if (cal_start && !cal_p) begin
                cals_seen++;
                chk("cal_after_ifm", ifm_seen, ifm_total);
                if (ti < ntiles) begin
                    chk("cal_after_wgt", wgt_seen, cum_wgt[ti]);
                    chk("cal_ofm_before", ofm_seen, (ti == 0) ? 0 : cum_ofm[ti - 1]);
                end else begin
                    chk("cal_tile_range", ti, ntiles - 1);
                end
            end
            cal_p = cal_start;

            if (done) begin
                dones_seen++;
                chk("done_ofm_beats", ofm_seen, ofm_total);
                chk("done_wgt_beats", wgt_seen, wgt_total);
                chk("done_tile_idx", ti, ntiles - 1);
            end
        end
    end

    // ---------------- sequences ----------------
    task automatic check_all_zero(input string tag);
        chk({tag, "_ctl"}, {ifm_req, wgt_req, ofm_req, cal_start, busy, done, cfg_err}, 0);
        chk({tag, "_ifm_addr"}, ifm_addr, 0);
        chk({tag, "_wgt_addr"}, wgt_addr, 0);
        chk({tag, "_ofm_addr"}, ofm_addr, 0);
        chk({tag, "_tile_state"}, {tile_idx, state_o}, 0);
        chk({tag, "_shape"}, {k_out, iw_out, ic_out, ow_out, oc_out, st_out}, 0);
    endtask

    task automatic pulse_start(input int k, iw, ic, ow, oc, st,
                               input logic [AW-1:0] ib, wb, ob);
        k_in = 4'(k); iw_in = 8'(iw); ic_in = 8'(ic); ow_in = 8'(ow); oc_in = 8'(oc); st_in = 2'(st);
        ifm_base = ib; wgt_base = wb; ofm_base = ob;
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        // Inputs must only matter on the accepting edge.
        k_in = 4'($urandom); iw_in = 8'($urandom); ic_in = 8'($urandom);
        ow_in = 8'($urandom); oc_in = 8'($urandom); st_in = 2'($urandom);
        ifm_base = $urandom; wgt_base = $urandom; ofm_base = $urandom;
    endtask

    task automatic run_layer(input int k, iw, ic, ow, oc, st,
                             input logic [AW-1:0] ib, wb, ob,
                             input int mode, input bit poke);
        bit poked;
        int cyc;
        rdy_mode = mode;
        stall_used = 0;
        build_model(k, iw, ic, ow, oc, ib, wb, ob);
        pulse_start(k, iw, ic, ow, oc, st, ib, wb, ob);
        @(negedge clk);
        chk("start_busy", busy, 1);
        chk("start_cfg_err_clear", cfg_err, 0);
        poked = 0;
        cyc = 0;
        while (dones_seen == 0 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (poke && !poked && cal_start) begin
                poked = 1;
                k_in = 4'd1; iw_in = 8'd9; ic_in = 8'd9; ow_in = 8'd9; oc_in = 8'd99; st_in = 2'd3;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        chk("layer_done_pulses", dones_seen, 1);
        repeat (2) @(negedge clk);
        chk("after_done_idle", {busy, done}, 0);
        chk("after_done_single_pulse", dones_seen, 1);
        chk("tiles_computed", cals_seen, ntiles);
        chk("queues_drained", q_ifm.size() + q_wgt.size() + q_ofm.size(), 0);
        chk("shape_latched", {k_out, iw_out, ic_out, ow_out, oc_out, st_out},
            {4'(k), 8'(iw), 8'(ic), 8'(ow), 8'(oc), 2'(st)});
    endtask

    initial begin
        int k, iw, ic, ow, oc, st, cyc;
        reset_model();
        #1;
        check_all_zero("reset_t0");
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("no_beat_after_release", {ifm_req, wgt_req, ofm_req, busy}, 0);

        // Single-tile layer.
        cal_dly = 1;
        run_layer(3, 4, 4, 2, 16, 1, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 0, 0);
        chk("l1_ifm_beats", ifm_seen, 16);
        chk("l1_wgt_beats", wgt_seen, 144);
        chk("l1_ofm_beats", ofm_seen, 16);

        // Two tiles: second tile skips IFM and continues weights/outputs.
        run_layer(3, 4, 4, 2, 20, 1, 32'h0000_4000, 32'h0001_0000, 32'h0002_0000, 0, 0);
        chk("l2_ifm_beats", ifm_seen, 16);
        chk("l2_ifm_beats_tile1", ifm_late, 0);
        chk("l2_wgt_beats", wgt_seen, 180);
        chk("l2_ofm_beats", ofm_seen, 20);
        chk("l2_t1_wgt_first", t1_wgt_first, 32'h0001_0000 + 576);
        chk("l2_t1_ofm_first", t1_ofm_first, 32'h0002_0000 + 64);
        chk("l2_t1_wgt_seen", t1_wgt_got, 1);

        // Zero-sized shape field is rejected.
        rdy_mode = 0;
        reset_model();
        pulse_start(3, 4, 0, 2, 16, 1, 32'h100, 32'h200, 32'h300);
        repeat (4) @(negedge clk);
        chk("cfg_err_set", cfg_err, 1);
        chk("cfg_err_idle", {busy, state_o}, 0);
        chk("cfg_err_no_done", dones_seen, 0);
        chk("cfg_err_no_beats", ifm_seen + wgt_seen + ofm_seen, 0);
        repeat (3) @(negedge clk);
        chk("cfg_err_holds", cfg_err, 1);
        reset_model();
        pulse_start(2, 3, 3, 3, 8, 0, 32'h100, 32'h200, 32'h300);
        repeat (4) @(negedge clk);
        chk("cfg_err_stride0", {cfg_err, busy}, 2'b10);
        run_layer(2, 3, 5, 3, 7, 2, 32'h0, 32'h8000, 32'hC000, 0, 0);
        chk("cfg_err_cleared_end", cfg_err, 0);

        // Weight stream stalls for 10 cycles while IFM finishes first.
        run_layer(3, 4, 4, 2, 16, 1, 32'h1000, 32'h2000, 32'h3000, 2, 0);
        chk("stall_cycles", wgt_stall_obs, 10);

        // Reset in the middle of STORE, then a clean rerun from tile 0.
        rdy_mode = 0;
        build_model(3, 4, 4, 2, 16, 32'h1000, 32'h2000, 32'h3000);
        pulse_start(3, 4, 4, 2, 16, 1, 32'h1000, 32'h2000, 32'h3000);
        cyc = 0;
        while (ofm_seen < 5 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        chk("reached_store_beat5", ofm_seen >= 5, 1);
        #1 rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_store");
        reset_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("no_beat_after_rerelease", {ifm_req, wgt_req, ofm_req, busy}, 0);
        run_layer(3, 4, 4, 2, 16, 1, 32'h5000, 32'h6000, 32'h7000, 0, 0);
        chk("rerun_ifm_beats", ifm_seen, 16);

        // Start pulsed during CAL is ignored.
        run_layer(3, 4, 4, 2, 20, 1, 32'hA000, 32'hB000, 32'hC000, 0, 1);
        chk("poke_layer_tiles", cals_seen, 2);

        // Randomized layers with random ready back-pressure.
        for (int n = 0; n < 6; n++) begin
            k  = $urandom_range(1, 3);
            iw = $urandom_range(1, 6);
            ic = $urandom_range(1, 6);
            ow = $urandom_range(1, 4);
            oc = (n == 0) ? 32 : $urandom_range(1, 40);
            st = $urandom_range(1, 3);
            cal_dly = $urandom_range(0, 5);
            run_layer(k, iw, ic, ow, oc, st, $urandom, $urandom, $urandom, 1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
